ones_word_gen: RTL

Generates a 16-bit word containing exactly a requested number of ones: the inverse of the ones-counter. It sits on the stimulus/encode side of the population-count path. A count is accepted over a valid/ready handshake. The word is built one bit per clock, each bit streamed out serially as it is decided. The finished word is then presented over a second valid/ready handshake.

---
 rtl/ones_pkg.sv | 18 +
 rtl/ones_bit_sched.sv | 30 +++
 rtl/ones_word_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ones_pkg.sv
// Shared constants, clamp limit and FSM state type for ones_word_gen.
// The ONES_WORD_GEN_SPREAD_EN build option only changes logic inside ones_bit_sched and ones_word_gen.
package ones_pkg;

  localparam int WIDTH = 16;
  localparam int CW    = $clog2(WIDTH + 1);
  localparam int IW    = $clog2(WIDTH);
  localparam int ACC_W = 6;

  localparam logic [CW-1:0] CLAMP_LIM = CW'(16);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/ones_bit_sched.sv
// Per-step bit decision: packed thermometer rule by default, or the evenly
// spread accumulator rule when ONES_WORD_GEN_SPREAD_EN is defined.
module ones_bit_sched
  import ones_pkg::*;
(
  input  logic [IW-1:0]    idx,
  input  logic [CW-1:0]    n,
  input  logic [ACC_W-1:0] acc,
  output logic             step_bit,
  output logic [ACC_W-1:0] acc_next
);

`ifdef ONES_WORD_GEN_SPREAD_EN
  logic [ACC_W-1:0] sum;
  logic             idx_unused;

  // The spread rule depends only on the running remainder, not the position.
  assign idx_unused = ^idx;

  always_comb begin
    sum      = acc + ACC_W'(n);
    step_bit = (sum >= ACC_W'(CLAMP_LIM));
    acc_next = step_bit ? (sum - ACC_W'(CLAMP_LIM)) : sum;
  end
`else
  assign step_bit = (CW'(idx) < n);
  assign acc_next = acc;
`endif

endmodule

// File: rtl/ones_word_gen.sv
// Builds a 16-bit word with exactly n ones, one bit per clock, streaming each bit
// serially; ONES_WORD_GEN_SPREAD_EN selects the evenly-spread bit placement.
module ones_word_gen
  import ones_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CW-1:0]    cnt_in,
  input  logic             cnt_valid,
  output logic             cnt_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             ser_bit,
  output logic             ser_valid,
  output logic             busy,
  output logic             err
);

  state_t           state;
  state_t           state_next;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    n;
  logic [CW-1:0]    n_clamp;
  logic             accept;
  logic             over;
  logic             last_step;
  logic             step_en;
  logic [IW-1:0]    s_idx;
  logic [CW-1:0]    s_n;
  logic [ACC_W-1:0] s_acc;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic             step_bit;
  logic             cnt_ready_d;
  logic             word_valid_d;
  logic             ser_bit_d;
  logic             ser_valid_d;
  logic             busy_d;
  logic             err_d;

  assign accept    = (state == IDLE) && cnt_valid;
  assign over      = (cnt_in > CLAMP_LIM);
  assign n_clamp   = over ? CLAMP_LIM : cnt_in;
  // idx wraps to 0 after bit 15 is emitted; that wrapped cycle closes BUILD.
  assign last_step = (state == BUILD) && (idx == '0);
  assign step_en   = (state == BUILD) && !last_step;

  // Bit 0 is decided in the accept cycle straight from the clamped input.
  assign s_idx = accept ? '0 : idx;
  assign s_n   = accept ? n_clamp : n;
  assign s_acc = accept ? '0 : acc;

  ones_bit_sched u_sched (
    .idx      (s_idx),
    .n        (s_n),
    .acc      (s_acc),
    .step_bit (step_bit),
    .acc_next (acc_next)
  );

`ifdef ONES_WORD_GEN_SPREAD_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (accept || step_en) begin
      acc <= acc_next;
    end
  end
`else
  logic acc_unused;

  assign acc        = '0;
  assign acc_unused = ^acc_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cnt_valid)  state_next = BUILD;
      BUILD:   if (last_step)  state_next = HOLD;
      HOLD:    if (word_ready) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_ready_d  = (state_next == IDLE);
    busy_d       = (state_next != IDLE);
    word_valid_d = (state_next == HOLD);
    ser_valid_d  = accept || step_en;
    ser_bit_d    = ser_valid_d && step_bit;
    err_d        = accept && over;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ready  <= 1'b1;
      busy       <= 1'b0;
      word_valid <= 1'b0;
      ser_valid  <= 1'b0;
      ser_bit    <= 1'b0;
      err        <= 1'b0;
    end else begin
      cnt_ready  <= cnt_ready_d;
      busy       <= busy_d;
      word_valid <= word_valid_d;
      ser_valid  <= ser_valid_d;
      ser_bit    <= ser_bit_d;
      err        <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      n        <= '0;
      word_out <= '0;
    end else if (accept) begin
      n        <= n_clamp;
      idx      <= IW'(1);
      word_out <= WIDTH'(step_bit);
    end else if (step_en) begin
      word_out[idx] <= step_bit;
      idx           <= idx + IW'(1);
    end
  end

endmodule
